cmp_window_stats: RTL and testbench

- Parametrised, handshaked successor to the team's registered 8-bit magnitude comparator.
- Compares WIDTH-bit operand pairs in signed or unsigned mode and registers a one-hot result per accepted beat.
- Accumulates GT/EQ/LT counts over a programmed window of samples, then pulses Done.
- Sits between a sample source (valid/ready) and the status/result register block.

---
 rtl/cmp_window_stats.sv | 127 ++++++++++++
 tb/tb_cmp_window_stats.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cmp_window_stats.sv
// cmp_window_stats: handshaked signed/unsigned magnitude comparator that
// registers a one-hot result per accepted beat and accumulates GT/EQ/LT
// counts over a programmed window of beats, pulsing Done when it ends.
module cmp_window_stats #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed_Mode,
  input  logic [CNT_W-1:0] Window_Len,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [2:0]       R,
  output logic             R_Valid,
  output logic [CNT_W-1:0] Gt_Count,
  output logic [CNT_W-1:0] Eq_Count,
  output logic [CNT_W-1:0] Lt_Count,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] beat_cnt;
  logic             mode_q;
  logic             accept;
  logic             last_beat;
  logic             a_gt_b;
  logic             a_eq_b;
  logic             a_lt_b;

  // Beats are only taken while a window is running; the window length is
  // never zero in RUN, so len_q - 1 cannot wrap.
  assign accept    = In_Valid && (state == RUN);
  assign last_beat = (beat_cnt == len_q - CNT_W'(1));

  assign In_Ready = (state == RUN);
  assign Busy     = (state == RUN);
  assign Done     = (state == DONE);

  // Magnitude compare of the current operands using the mode latched at Start.
  always_comb begin
    a_eq_b = (A == B);
    a_gt_b = 1'b0;
    a_lt_b = 1'b0;
    if (mode_q) begin
      a_gt_b = ($signed(A) > $signed(B));
      a_lt_b = ($signed(A) < $signed(B));
    end else begin
      a_gt_b = (A > B);
      a_lt_b = (A < B);
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: an empty window skips straight to DONE; the final beat
  // moves to DONE on the same edge that registers its result.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (Start) begin
          next_state = (Window_Len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept && last_beat) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Window setup, result register and per-class counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      len_q    <= '0;
      mode_q   <= 1'b0;
      beat_cnt <= '0;
      R        <= 3'b000;
      R_Valid  <= 1'b0;
      Gt_Count <= '0;
      Eq_Count <= '0;
      Lt_Count <= '0;
    end else begin
      R_Valid <= 1'b0;
      if ((state == IDLE) && Start) begin
        len_q    <= Window_Len;
        mode_q   <= Signed_Mode;
        beat_cnt <= '0;
        Gt_Count <= '0;
        Eq_Count <= '0;
        Lt_Count <= '0;
      end
      if (accept) begin
        R        <= {a_gt_b, a_eq_b, a_lt_b};
        R_Valid  <= 1'b1;
        beat_cnt <= beat_cnt + CNT_W'(1);
        if (a_gt_b) Gt_Count <= Gt_Count + CNT_W'(1);
        if (a_eq_b) Eq_Count <= Eq_Count + CNT_W'(1);
        if (a_lt_b) Lt_Count <= Lt_Count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cmp_window_stats.sv
// tb_cmp_window_stats: directed self-checking bench for cmp_window_stats.
module tb_cmp_window_stats;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             Clk;
  logic             Reset;
  logic             Start;
  logic             Signed_Mode;
  logic [CNT_W-1:0] Window_Len;
  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       R;
  logic             R_Valid;
  logic [CNT_W-1:0] Gt_Count;
  logic [CNT_W-1:0] Eq_Count;
  logic [CNT_W-1:0] Lt_Count;
  logic             Busy;
  logic             Done;

  int checkCount = 0;
  int passCount  = 0;
  int doneSeen   = 0;
  int rvSeen     = 0;
  int doneBase;
  int rvBase;

  cmp_window_stats #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Signed_Mode(Signed_Mode),
    .Window_Len(Window_Len), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .A(A), .B(B), .R(R), .R_Valid(R_Valid), .Gt_Count(Gt_Count),
    .Eq_Count(Eq_Count), .Lt_Count(Lt_Count), .Busy(Busy), .Done(Done)
  );

  // Free-running clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge Clk) begin
    if (Done) doneSeen++;
    if (R_Valid) rvSeen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic startWindow(input logic [CNT_W-1:0] len, input logic mode);
    Start = 1'b1;
    Window_Len = len;
    Signed_Mode = mode;
    tick();
    Start = 1'b0;
  endtask

  task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
    In_Valid = valid;
    A = a;
    B = b;
    tick();
  endtask

  task automatic checkCounts(input string tag, input int gt, input int eq, input int lt);
    checkOutput({tag, "_gt"}, 32'(Gt_Count), gt);
    checkOutput({tag, "_eq"}, 32'(Eq_Count), eq);
    checkOutput({tag, "_lt"}, 32'(Lt_Count), lt);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Signed_Mode = 1'b0; Window_Len = '0;
    In_Valid = 1'b0; A = '0; B = '0;
    tick(); tick();
    Reset = 1'b0;

    // Reset state and idle quietness
    for (int i = 0; i < 5; i++) tick();
    checkOutput("rst_R", 32'(R), 0);
    checkCounts("rst", 0, 0, 0);
    checkOutput("rst_ready", 32'(In_Ready), 0);
    checkOutput("rst_busy", 32'(Busy), 0);
    checkOutput("rst_done_pulses", doneSeen, 0);

    // Window of 3, unsigned, back-to-back beats
    startWindow(16'd3, 1'b0);
    checkOutput("w3_busy", 32'(Busy), 1);
    checkOutput("w3_ready", 32'(In_Ready), 1);
    applyStimulus(1'b1, 8'd5, 8'd3);
    checkOutput("w3_r1", 32'(R), 3'b100);
    checkOutput("w3_rv1", 32'(R_Valid), 1);
    checkOutput("w3_done1", 32'(Done), 0);
    applyStimulus(1'b1, 8'd7, 8'd7);
    checkOutput("w3_r2", 32'(R), 3'b010);
    checkOutput("w3_rv2", 32'(R_Valid), 1);
    applyStimulus(1'b1, 8'd2, 8'd9);
    In_Valid = 1'b0;
    checkOutput("w3_r3", 32'(R), 3'b001);
    checkOutput("w3_rv3", 32'(R_Valid), 1);
    checkOutput("w3_done3", 32'(Done), 1);
    checkOutput("w3_ready_done", 32'(In_Ready), 0);
    checkCounts("w3", 1, 1, 1);
    tick();
    checkOutput("w3_idle_ready", 32'(In_Ready), 0);
    checkOutput("w3_idle_done", 32'(Done), 0);
    checkOutput("w3_idle_rv", 32'(R_Valid), 0);
    checkOutput("w3_idle_Rhold", 32'(R), 3'b001);

    // Signed versus unsigned interpretation
    startWindow(16'd1, 1'b0);
    applyStimulus(1'b1, 8'hFF, 8'h01);
    In_Valid = 1'b0;
    checkOutput("uns_R", 32'(R), 3'b100);
    checkCounts("uns", 1, 0, 0);
    checkOutput("uns_done", 32'(Done), 1);
    tick();
    startWindow(16'd1, 1'b1);
    applyStimulus(1'b1, 8'hFF, 8'h01);
    In_Valid = 1'b0;
    checkOutput("sgn_R", 32'(R), 3'b001);
    checkCounts("sgn", 0, 0, 1);
    tick();
    startWindow(16'd1, 1'b1);
    applyStimulus(1'b1, 8'h80, 8'h7F);
    In_Valid = 1'b0;
    checkOutput("sgn_min_R", 32'(R), 3'b001);
    tick();

    // Window of 4 with valid gaps and a stray Start during RUN
    doneBase = doneSeen;
    rvBase = rvSeen;
    startWindow(16'd4, 1'b0);
    applyStimulus(1'b1, 8'd3, 8'd3);
    applyStimulus(1'b0, 8'd0, 8'd0);
    checkOutput("gap_rv_low", 32'(R_Valid), 0);
    checkOutput("gap_Rhold", 32'(R), 3'b010);
    Start = 1'b1; Window_Len = 16'd1;
    applyStimulus(1'b0, 8'd0, 8'd0);
    Start = 1'b0;
    checkOutput("gap_busy_after_start", 32'(Busy), 1);
    applyStimulus(1'b1, 8'd9, 8'd1);
    checkOutput("gap_done_early", 32'(Done), 0);
    applyStimulus(1'b1, 8'd1, 8'd9);
    applyStimulus(1'b0, 8'd0, 8'd0);
    checkOutput("gap_busy_mid", 32'(Busy), 1);
    checkOutput("gap_no_done_yet", doneSeen - doneBase, 0);
    applyStimulus(1'b1, 8'd4, 8'd4);
    In_Valid = 1'b0;
    checkOutput("gap_done", 32'(Done), 1);
    checkOutput("gap_R4", 32'(R), 3'b010);
    checkCounts("gap", 1, 2, 1);
    tick();
    checkOutput("gap_rv_pulses", rvSeen - rvBase, 4);
    checkOutput("gap_done_pulses", doneSeen - doneBase, 1);

    // Empty window: Done next cycle, no beats taken despite In_Valid
    rvBase = rvSeen;
    In_Valid = 1'b1; A = 8'd1; B = 8'd2;
    startWindow(16'd0, 1'b0);
    checkOutput("w0_done", 32'(Done), 1);
    checkOutput("w0_ready", 32'(In_Ready), 0);
    checkCounts("w0", 0, 0, 0);
    tick();
    In_Valid = 1'b0;
    checkOutput("w0_idle_ready", 32'(In_Ready), 0);
    checkOutput("w0_done_gone", 32'(Done), 0);
    checkOutput("w0_rv_pulses", rvSeen - rvBase, 0);

    // Reset mid-window aborts it; next window completes normally
    doneBase = doneSeen;
    startWindow(16'd5, 1'b0);
    applyStimulus(1'b1, 8'd2, 8'd1);
    applyStimulus(1'b1, 8'd2, 8'd1);
    checkOutput("abort_gt_before", 32'(Gt_Count), 2);
    In_Valid = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checkCounts("abort", 0, 0, 0);
    checkOutput("abort_busy", 32'(Busy), 0);
    checkOutput("abort_R", 32'(R), 0);
    tick(); tick();
    checkOutput("abort_no_done", doneSeen - doneBase, 0);
    startWindow(16'd1, 1'b0);
    applyStimulus(1'b1, 8'd6, 8'd6);
    In_Valid = 1'b0;
    checkOutput("after_done", 32'(Done), 1);
    checkCounts("after", 0, 1, 0);
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
